// File: rtl/freq_pkg.sv
// ---------------------------------------------------------------------------
// freq_pkg
//
// Shared definitions for the multi-channel frequency counter.
//   - state_e      : gate controller states (IDLE, GATE, PUBLISH)
//   - DEF_*        : default values for the block's parameters
//   - EDGE_LATENCY : cycles from a rising input transition to its edge pulse
//   - edge_latency : the same latency for an arbitrary synchroniser depth
//
// No ports; imported by edge_sync and freq_counter_multi.
// ---------------------------------------------------------------------------
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATE    = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 40;
  localparam int DEF_GATE_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;

  // A rising transition on a raw input shows up as an edge pulse this many
  // cycles later: one cycle per synchroniser flop plus the registered
  // edge detector.
  localparam int EDGE_LATENCY = DEF_SYNC_STAGES + 1;

  function automatic int edge_latency(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
//
// One measured channel: a SYNC_STAGES-deep synchroniser followed by a
// registered rising-edge detector. A rising transition on sig_async yields
// edge_pulse high for exactly one cycle, SYNC_STAGES+1 cycles later.
//
// Ports:
//   clk        in  1  system clock
//   rst        in  1  asynchronous active-high reset
//   sig_async  in  1  raw asynchronous input
//   edge_pulse out 1  one-cycle pulse per synchronised rising edge
// ---------------------------------------------------------------------------
module edge_sync
  import freq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_async,
  output logic edge_pulse
);

  // The chain holds the synchroniser flops plus one extra flop that keeps
  // the previous synchronised value for the edge detector, so its length
  // equals the edge latency.
  localparam int CHAIN_W = edge_latency(SYNC_STAGES);

  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic               edge_q, edge_d;

  // Shift the raw input in at bit 0. Bit SYNC_STAGES-1 is the last
  // synchroniser stage and bit SYNC_STAGES is its one-cycle-old copy.
  always_comb begin
    chain_d = {chain_q[CHAIN_W-2:0], sig_async};
    edge_d  = chain_q[SYNC_STAGES-1] & ~chain_q[SYNC_STAGES];
  end

  // Synchroniser and edge register; all cleared by reset so no stale
  // edge can leak into the first window after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      edge_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/freq_counter_multi.sv
// ---------------------------------------------------------------------------
// freq_counter_multi
//
// Multi-channel frequency counter. Counts synchronised rising edges on each
// of NUM_CH asynchronous inputs during a gate window of gate_len clk cycles
// and publishes all counts together with a one-cycle valid strobe.
// Supports one-shot and continuous (back-to-back) windows and reports
// per-channel saturation.
//
// Ports:
//   clk         in  1             system clock
//   rst         in  1             asynchronous active-high reset
//   enable      in  1             block enable; low aborts an open window
//   continuous  in  1             restart a window right after each publish
//   start       in  1             one-cycle pulse, begins a window when idle
//   gate_len    in  GATE_W        window length in cycles (0 behaves as 1)
//   sig_in      in  NUM_CH        asynchronous measured signals
//   count_out   out NUM_CH*CNT_W  published counts, ch k at [k*CNT_W +: CNT_W]
//   overflow    out NUM_CH        per-channel saturation of the published window
//   valid       out 1             strobe when count_out/overflow update
//   busy        out 1             high while a window is open
// ---------------------------------------------------------------------------
module freq_counter_multi
  import freq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     continuous,
  input  logic                     start,
  input  logic [GATE_W-1:0]        gate_len,
  input  logic [NUM_CH-1:0]        sig_in,
  output logic [NUM_CH*CNT_W-1:0]  count_out,
  output logic [NUM_CH-1:0]        overflow,
  output logic                     valid,
  output logic                     busy
);

  state_e                         state_q, state_d;
  logic [GATE_W-1:0]              timer_q, timer_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]              ovf_q, ovf_d;
  logic [NUM_CH*CNT_W-1:0]        count_out_q, count_out_d;
  logic [NUM_CH-1:0]              overflow_q, overflow_d;
  logic                           valid_q, valid_d;

  logic [NUM_CH-1:0]              edge_vec;
  logic [GATE_W-1:0]              load_len;

  // One synchroniser/edge detector per channel.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
      .clk       (clk),
      .rst       (rst),
      .sig_async (sig_in[k]),
      .edge_pulse(edge_vec[k])
    );
  end

  // A zero gate length would never reach the last-cycle test, so it is
  // promoted to a single-cycle window.
  assign load_len = (gate_len == '0) ? GATE_W'(1) : gate_len;

  // Next-state logic for the gate controller, timer, channel counters and
  // published results. The timer holds the number of GATE cycles still to
  // run including the current one, so timer_q==1 marks the last cycle; the
  // results are captured on that cycle from the already-updated counter
  // values so the last cycle's edge is included and valid lines up with
  // the PUBLISH state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    count_out_d = count_out_q;
    overflow_d  = overflow_q;
    valid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (start || continuous)) begin
          timer_d = load_len;
          cnt_d   = '0;
          ovf_d   = '0;
          state_d = GATE;
        end
      end

      GATE: begin
        if (!enable) begin
          cnt_d   = '0;
          ovf_d   = '0;
          state_d = IDLE;
        end else begin
          // A saturated counter holds at all-ones; a further edge marks
          // the channel's sticky overflow instead of wrapping.
          for (int k = 0; k < NUM_CH; k++) begin
            if (edge_vec[k]) begin
              if (&cnt_q[k]) begin
                ovf_d[k] = 1'b1;
              end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
              end
            end
          end
          timer_d = timer_q - GATE_W'(1);
          if (timer_q == GATE_W'(1)) begin
            count_out_d = cnt_d;
            overflow_d  = ovf_d;
            valid_d     = 1'b1;
            state_d     = PUBLISH;
          end
        end
      end

      PUBLISH: begin
        // Restarting here leaves a one-cycle gap; edges seen during this
        // cycle are dropped because the counters are cleared.
        if (enable && continuous) begin
          timer_d = load_len;
          cnt_d   = '0;
          ovf_d   = '0;
          state_d = GATE;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any window in progress
  // and clears the published results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= '0;
      count_out_q <= '0;
      overflow_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      count_out_q <= count_out_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
    end
  end

  assign count_out = count_out_q;
  assign overflow  = overflow_q;
  assign valid     = valid_q;
  assign busy      = (state_q == GATE);

endmodule

// File: doc/freq_counter_multi.md
Name: freq_counter_multi

Overview:
- Multi-channel, single-clock frequency counter. Counts rising edges on NUM_CH asynchronous inputs during an internally timed gate window of programmable length.
- At the end of each window it publishes per-channel counts with a one-cycle valid strobe.
- Supports one-shot and continuous (back-to-back window) modes, and reports per-channel saturation.
- Sits between raw external pulse inputs and the measurement/readout logic.

Parameters:
- NUM_CH, 4, number of measured input channels (>=1)
- CNT_W, 40, width of each channel's edge counter and result
- GATE_W, 32, width of the gate-length input
- SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  block enable; deassertion aborts any window in progress
- continuous  in  1  1 = restart a new window immediately after each publish
- start  in  1  one-cycle pulse; begins a window when idle
- gate_len  in  GATE_W  window length in clk cycles, sampled at window start
- sig_in  in  NUM_CH  asynchronous measured signals
- count_out  out  NUM_CH*CNT_W  published counts; channel k occupies bits [k*CNT_W +: CNT_W]
- overflow  out  NUM_CH  per-channel saturation flag for the published window
- valid  out  1  one-cycle strobe when count_out/overflow update
- busy  out  1  high while a window is open

Behaviour:
- Reset: count_out=0, overflow=0, valid=0, busy=0; internal counters, timer and synchronisers cleared; FSM=IDLE. Reset applies immediately and asynchronously; an interrupted window is discarded.
- Input path, per channel:
  - SYNC_STAGES-flop synchroniser, followed by one registered edge detector: edge = sync_last & ~prev.
  - A rising transition on sig_in produces edge high SYNC_STAGES+1 cycles later, for exactly one cycle.
- FSM states: IDLE, GATE, PUBLISH.
  - IDLE: busy=0. When enable & (start | continuous):
    - load timer with gate_len; gate_len==0 is treated as 1
    - clear channel counters
    - go to GATE.
  - GATE: busy=1.
    - Each cycle, each channel counter increments by 1 if its edge is high.
    - Timer decrements each cycle. The window is exactly the loaded number of cycles; edges in the first and last GATE cycles both count.
    - At the end of the last GATE cycle, go to PUBLISH.
  - PUBLISH (one cycle): count_out/overflow loaded from counters (including the last GATE cycle's edge), valid=1, busy=0.
    - Next state: if enable & continuous, reload timer from gate_len, clear counters, go to GATE. The gap between windows is exactly 1 cycle, and edges in the PUBLISH cycle are not counted.
    - Otherwise go to IDLE.
- enable low in GATE: return to IDLE next cycle, counters cleared, no valid, count_out/overflow retain their previous values.
- start while in GATE or PUBLISH is ignored.
- Saturation: a counter at all-ones stays there and sets its channel's sticky overflow bit, which is cleared at window start. overflow is published alongside count_out.
- A zero count is published normally (valid still pulses).
- count_out and overflow hold their values between valid strobes.
- Arithmetic: all counters unsigned CNT_W; timer unsigned GATE_W. There is no wrap-around anywhere.

Decomposition:
- Shared package freq_pkg: FSM state enum (IDLE, GATE, PUBLISH); default parameter constants; localparam for the edge latency (SYNC_STAGES+1).
- Sub-module edge_sync: one channel's synchroniser plus edge detector, parameterised by SYNC_STAGES, instantiated NUM_CH times in a generate loop.
- The top level holds the FSM, timer, counters and output registers.

Test Plan:
- NUM_CH=2, gate_len=100; ch0 period 10 clk, ch1 period 25 clk, phase-aligned so no edge lands on a window boundary; start pulse -> after 101 cycles (100 GATE cycles plus the PUBLISH cycle) valid pulses once; count_out ch0=10, ch1=4; overflow=0; busy low.
- Boundary: single edge on ch0 arriving in the first GATE cycle and another in the last GATE cycle, gate_len=5 -> ch0=2. An edge arriving in the PUBLISH cycle -> not counted in the next window.
- continuous=1, gate_len=50, ch0 period 5 -> valid every 51 cycles; each result=10 (±1 at a boundary is not allowed with aligned stimulus); no window is skipped.
- CNT_W=4, ch0 toggling every 2 clk, gate_len=64 -> ch0 count_out=15, overflow[0]=1, overflow[1]=0. A following window with 3 edges -> count=3, overflow[0]=0.
- Abort: enable dropped mid-window -> no valid, busy=0 next cycle, count_out unchanged. gate_len=0 with start -> 1-cycle window, valid 2 cycles after start.
- Reset asserted mid-GATE with prior results non-zero -> all outputs 0 immediately; no valid after release until a new start.
